// File: rtl/dram_traffic_gen.sv
// DRAM bandwidth/traffic generator driving the DRAMCON user interface.
// Define DRAM_TG_CHECK_EN to build the read-back data comparator (ERR_CNT).
module dram_traffic_gen #(
  parameter int          DATA_W   = 512,
  parameter int          ADDR_W   = 32,
  parameter int          CNT_W    = 32,
  parameter int          RAND_MSB = 28,
  parameter logic [31:0] SEED     = 32'd1
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic              RAND_EN,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  ACCESS_CNT,
  input  logic [CNT_W-1:0]  BLOCKS,
  output logic [1:0]        D_REQ,
  output logic [ADDR_W-1:0] D_INITADR,
  output logic [CNT_W-1:0]  D_ELEM,
  input  logic              D_BUSY,
  output logic [DATA_W-1:0] D_DIN,
  input  logic              D_W,
  input  logic [DATA_W-1:0] D_DOUT,
  input  logic              D_DOUTEN,
  output logic              RUNNING,
  output logic              DONE,
  output logic [CNT_W-1:0]  W_CYCLE,
  output logic [CNT_W-1:0]  R_CYCLE,
  output logic [CNT_W-1:0]  ERR_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [1:0]  REQ_WR = 2'b10;
  localparam logic [1:0]  REQ_RD = 2'b01;
  localparam logic [31:0] XS_X0  = 32'd123456789;
  localparam logic [31:0] XS_Y0  = 32'd362436069;
  localparam logic [31:0] XS_Z0  = 32'd521288629;
  localparam logic [31:0] XS_W0  = 32'd88675123 ^ SEED;
  localparam logic [31:0] RAND_MASK =
    32'((33'h1 << (RAND_MSB + 1)) - 33'h1) & ~32'h7;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t            state, state_nx;
  logic [1:0]        mode_q;
  logic              rand_en_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  blocks_q;
  logic [CNT_W-1:0]  issued;
  logic [ADDR_W-1:0] seq_addr;
  logic [31:0]       wcnt;
  logic [31:0]       xs_x, xs_y, xs_z, xs_w;

  logic start_acc, issue, count, exit_phase, to_read, reseed;

  // Next-state and per-cycle phase decision
  always_comb begin
    state_nx   = state;
    start_acc  = 1'b0;
    issue      = 1'b0;
    count      = 1'b0;
    exit_phase = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          state_nx  = (MODE == 2'd1) ? S_READ : S_WRITE;
        end
      end
      S_WRITE, S_READ: begin
        if (D_REQ != 2'b00) begin
          count = 1'b1;
        end else if (!D_BUSY && (issued == acc_q)) begin
          exit_phase = 1'b1;
          state_nx   = ((state == S_READ) || (mode_q == 2'd0)) ? S_FIN : S_READ;
        end else if (!D_BUSY) begin
          issue = 1'b1;
          count = 1'b1;
        end else begin
          count = 1'b1;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign to_read = exit_phase && (state == S_WRITE) && (mode_q != 2'd0);
  assign reseed  = start_acc || to_read;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Random address keeps rand[RAND_MSB:3] with the xorshift MSB masked off
  logic [31:0]          rand_bits;
  logic [ADDR_W+31:0]   rand_wide;
  logic [ADDR_W-1:0]    rand_addr;
  logic [ADDR_W-1:0]    step;
  assign rand_bits = {1'b0, xs_w[30:0]} & RAND_MASK;
  assign rand_wide = {{ADDR_W{1'b0}}, rand_bits};
  assign rand_addr = rand_wide[ADDR_W-1:0];
  assign step      = ADDR_W'({blocks_q, 3'b000});

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      xs_x <= XS_X0;
      xs_y <= XS_Y0;
      xs_z <= XS_Z0;
      xs_w <= XS_W0;
    end else if (reseed) begin
      xs_x <= XS_X0;
      xs_y <= XS_Y0;
      xs_z <= XS_Z0;
      xs_w <= XS_W0;
    end else begin
      xs_x <= xs_y;
      xs_y <= xs_z;
      xs_z <= xs_w;
      xs_w <= (xs_w ^ (xs_w >> 19)) ^ ((xs_x ^ (xs_x << 11)) ^ ((xs_x ^ (xs_x << 11)) >> 8));
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      mode_q    <= 2'd0;
      rand_en_q <= 1'b0;
      base_q    <= '0;
      acc_q     <= '0;
      blocks_q  <= '0;
      issued    <= '0;
      seq_addr  <= '0;
      D_REQ     <= 2'b00;
      D_INITADR <= '0;
      D_ELEM    <= '0;
      RUNNING   <= 1'b0;
      DONE      <= 1'b0;
      W_CYCLE   <= '0;
      R_CYCLE   <= '0;
    end else begin
      D_REQ <= 2'b00;
      if (start_acc) begin
        mode_q    <= MODE;
        rand_en_q <= RAND_EN;
        base_q    <= BASE_ADDR;
        acc_q     <= ACCESS_CNT;
        blocks_q  <= BLOCKS;
        issued    <= '0;
        seq_addr  <= BASE_ADDR;
        W_CYCLE   <= '0;
        R_CYCLE   <= '0;
        RUNNING   <= 1'b1;
        DONE      <= 1'b0;
      end
      if (issue) begin
        D_REQ     <= (state == S_WRITE) ? REQ_WR : REQ_RD;
        D_INITADR <= rand_en_q ? rand_addr : seq_addr;
        D_ELEM    <= blocks_q;
        issued    <= issued + CNT_W'(1);
        seq_addr  <= seq_addr + step;
      end
      if (count) begin
        if (state == S_WRITE) W_CYCLE <= sat_inc(W_CYCLE);
        else                  R_CYCLE <= sat_inc(R_CYCLE);
      end
      // Read phase restarts the address stream so it replays the write order
      if (to_read) begin
        issued   <= '0;
        seq_addr <= base_q;
      end
      if (state == S_FIN) begin
        DONE    <= 1'b1;
        RUNNING <= 1'b0;
      end
    end
  end

  // Write data counter runs in every state so late D_W beats are still consumed
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)        wcnt <= '0;
    else if (start_acc) wcnt <= '0;
    else if (D_W)      wcnt <= wcnt + 32'd1;
  end

  assign D_DIN = DATA_W'(wcnt);

`ifdef DRAM_TG_CHECK_EN
  logic [31:0]      erd;
  logic [CNT_W-1:0] err_cnt;

  // Random addresses may overlap and overwrite, so only sequential runs compare
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      erd     <= '0;
      err_cnt <= '0;
    end else if (start_acc) begin
      erd     <= '0;
      err_cnt <= '0;
    end else if (D_DOUTEN) begin
      erd <= erd + 32'd1;
      if (!rand_en_q && (D_DOUT != DATA_W'(erd)))
        err_cnt <= sat_inc(err_cnt);
    end
  end

  assign ERR_CNT = err_cnt;
`else
  logic unused_dout;
  assign unused_dout = ^{D_DOUT, D_DOUTEN};
  assign ERR_CNT     = '0;
`endif

endmodule

// File: tb/tb_dram_traffic_gen.sv
// Directed bench for dram_traffic_gen with a small reactive DRAMCON responder.
module tb_dram_traffic_gen;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              CLK = 1'b0;
  logic              RST_X;
  logic              START;
  logic [1:0]        MODE;
  logic              RAND_EN;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [CNT_W-1:0]  ACCESS_CNT;
  logic [CNT_W-1:0]  BLOCKS;
  logic [1:0]        D_REQ;
  logic [ADDR_W-1:0] D_INITADR;
  logic [CNT_W-1:0]  D_ELEM;
  logic              D_BUSY   = 1'b0;
  logic [DATA_W-1:0] D_DIN;
  logic              D_W      = 1'b0;
  logic [DATA_W-1:0] D_DOUT   = '0;
  logic              D_DOUTEN = 1'b0;
  logic              RUNNING;
  logic              DONE;
  logic [CNT_W-1:0]  W_CYCLE;
  logic [CNT_W-1:0]  R_CYCLE;
  logic [CNT_W-1:0]  ERR_CNT;

  dram_traffic_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RAND_MSB(28), .SEED(32'd1)
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .START(START), .MODE(MODE), .RAND_EN(RAND_EN),
    .BASE_ADDR(BASE_ADDR), .ACCESS_CNT(ACCESS_CNT), .BLOCKS(BLOCKS),
    .D_REQ(D_REQ), .D_INITADR(D_INITADR), .D_ELEM(D_ELEM), .D_BUSY(D_BUSY),
    .D_DIN(D_DIN), .D_W(D_W), .D_DOUT(D_DOUT), .D_DOUTEN(D_DOUTEN),
    .RUNNING(RUNNING), .DONE(DONE), .W_CYCLE(W_CYCLE), .R_CYCLE(R_CYCLE),
    .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  logic busy_mode = 1'b0;

`ifdef DRAM_TG_CHECK_EN
  localparam logic [63:0] EXP_ERR = 64'd1;
`else
  localparam logic [63:0] EXP_ERR = 64'd0;
`endif

  // Responder state
  logic [ADDR_W-1:0] wq[$];
  logic [ADDR_W-1:0] rq[$];
  int   wbeats = 0, rbeats = 0, rbeat_idx = 0, bcnt = 0, pulses = 0;
  logic pend = 1'b0, prev_running = 1'b0;

  // DRAMCON model: one busy window of 10 cycles after each request when
  // busy_mode is set, D_W beats for writes, read beats echo the write order
  // with the 5th beat corrupted.
  always @(posedge CLK) begin
    #1;
    if (!RST_X) begin
      D_W = 1'b0; D_DOUTEN = 1'b0; D_BUSY = 1'b0;
      wbeats = 0; rbeats = 0; bcnt = 0; pend = 1'b0; prev_running = 1'b0;
    end else begin
      if (RUNNING && !prev_running) begin
        wq.delete(); rq.delete(); rbeat_idx = 0;
      end
      prev_running = RUNNING;
      if (wbeats > 0) begin D_W = 1'b1; wbeats--; end
      else D_W = 1'b0;
      if (rbeats > 0) begin
        D_DOUTEN = 1'b1;
        D_DOUT   = (rbeat_idx == 4) ? ~64'(rbeat_idx) : 64'(rbeat_idx);
        rbeat_idx++; rbeats--;
      end else D_DOUTEN = 1'b0;
      if (D_BUSY) begin
        bcnt--;
        if (bcnt == 0) D_BUSY = 1'b0;
      end
      if (D_REQ != 2'b00) pend = 1'b1;
      else if (pend) begin
        pend = 1'b0;
        if (busy_mode) begin D_BUSY = 1'b1; bcnt = 10; end
      end
      if (D_REQ == 2'b10) begin wq.push_back(D_INITADR); wbeats += int'(D_ELEM); pulses++; end
      if (D_REQ == 2'b01) begin rq.push_back(D_INITADR); rbeats += int'(D_ELEM); pulses++; end
    end
  end

  function automatic logic [63:0] wq_at(int i);
    return (i < wq.size()) ? 64'(wq[i]) : 64'hDEAD;
  endfunction
  function automatic logic [63:0] rq_at(int i);
    return (i < rq.size()) ? 64'(rq[i]) : 64'hBEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic r, input logic [31:0] base,
                           input logic [31:0] acc, input logic [31:0] blk);
    MODE = m; RAND_EN = r; BASE_ADDR = base; ACCESS_CNT = acc; BLOCKS = blk;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!DONE && n < budget) begin @(negedge CLK); n++; end
    check(tag, 64'(DONE), 64'd1);
  endtask

  int p0;

  initial begin
    RST_X = 1'b0; START = 1'b0; MODE = 2'd0; RAND_EN = 1'b0;
    BASE_ADDR = '0; ACCESS_CNT = '0; BLOCKS = '0;
    repeat (3) @(negedge CLK);
    check("rst_req",     64'(D_REQ),     64'd0);
    check("rst_adr",     64'(D_INITADR), 64'd0);
    check("rst_din",     64'(D_DIN),     64'd0);
    check("rst_running", 64'(RUNNING),   64'd0);
    check("rst_done",    64'(DONE),      64'd0);
    check("rst_wcyc",    64'(W_CYCLE),   64'd0);
    check("rst_err",     64'(ERR_CNT),   64'd0);
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);

    // Write-only, sequential, no busy
    start_run(2'd0, 1'b0, 32'h100, 32'd3, 32'd4);
    check("seq_running", 64'(RUNNING), 64'd1);
    wait_done("seq_done", 40);
    check("seq_wcyc",  64'(W_CYCLE), 64'd6);
    check("seq_rcyc",  64'(R_CYCLE), 64'd0);
    check("seq_nreq",  64'(wq.size()), 64'd3);
    check("seq_a0",    wq_at(0), 64'h100);
    check("seq_a1",    wq_at(1), 64'h120);
    check("seq_a2",    wq_at(2), 64'h140);
    check("seq_nrd",   64'(rq.size()), 64'd0);
    check("seq_elem",  64'(D_ELEM), 64'd4);
    repeat (15) @(negedge CLK);
    check("seq_din",   64'(D_DIN), 64'd12);
    check("seq_run_off", 64'(RUNNING), 64'd0);

    // Write-then-read with 10-cycle busy after every request
    busy_mode = 1'b1;
    start_run(2'd2, 1'b0, 32'h2000, 32'd2, 32'd2);
    wait_done("busy_done", 200);
    check("busy_wcyc", 64'(W_CYCLE), 64'd24);
    check("busy_rcyc", 64'(R_CYCLE), 64'd24);
    check("busy_w0",   wq_at(0), 64'h2000);
    check("busy_w1",   wq_at(1), 64'h2010);
    check("busy_r0",   rq_at(0), 64'h2000);
    check("busy_r1",   rq_at(1), 64'h2010);
    repeat (15) @(negedge CLK);

    start_run(2'd3, 1'b1, 32'h2000, 32'd2, 32'd2);
    wait_done("rbusy_done", 200);
    check("rbusy_wcyc", 64'(W_CYCLE), 64'd24);
    check("rbusy_rcyc", 64'(R_CYCLE), 64'd24);
    check("rbusy_w0",   wq_at(0), 64'h0549_1330);
    check("rbusy_r0",   rq_at(0), wq_at(0));
    check("rbusy_r1",   rq_at(1), wq_at(1));
    check("rbusy_nrd",  64'(rq.size()), 64'd2);
    busy_mode = 1'b0;
    repeat (15) @(negedge CLK);

    // Read-back check: one corrupted beat
    start_run(2'd2, 1'b0, 32'h0, 32'd2, 32'd4);
    wait_done("chk_done", 60);
    repeat (20) @(negedge CLK);
    check("chk_err",  64'(ERR_CNT), EXP_ERR);
    check("chk_din",  64'(D_DIN),   64'd8);
    start_run(2'd2, 1'b1, 32'h0, 32'd2, 32'd4);
    wait_done("chk_rand_done", 60);
    repeat (20) @(negedge CLK);
    check("chk_rand_err", 64'(ERR_CNT), 64'd0);

    // Zero accesses: one cycle per phase, no request
    p0 = pulses;
    start_run(2'd2, 1'b0, 32'h0, 32'd0, 32'd4);
    repeat (2) @(negedge CLK);
    check("zero_notyet", 64'(DONE), 64'd0);
    @(negedge CLK);
    check("zero_done",  64'(DONE),    64'd1);
    check("zero_wcyc",  64'(W_CYCLE), 64'd0);
    check("zero_rcyc",  64'(R_CYCLE), 64'd0);
    check("zero_pulse", 64'(pulses - p0), 64'd0);
    repeat (3) @(negedge CLK);

    // START during a run is ignored
    start_run(2'd0, 1'b0, 32'h100, 32'd3, 32'd4);
    @(negedge CLK);
    check("ign_running", 64'(RUNNING), 64'd1);
    START = 1'b1; @(negedge CLK); START = 1'b0;
    wait_done("ign_done", 40);
    check("ign_wcyc",  64'(W_CYCLE), 64'd6);
    check("ign_nreq",  64'(wq.size()), 64'd3);
    check("ign_a2",    wq_at(2), 64'h140);
    repeat (15) @(negedge CLK);

    // Asynchronous reset while a write request is on the bus
    busy_mode = 1'b1;
    start_run(2'd0, 1'b0, 32'h400, 32'd3, 32'd4);
    for (int n = 0; n < 20 && D_REQ != 2'b10; n++) @(negedge CLK);
    check("pre_rst_req", 64'(D_REQ), 64'h2);
    #1 RST_X = 1'b0;
    #1;
    check("arst_req",     64'(D_REQ),     64'd0);
    check("arst_adr",     64'(D_INITADR), 64'd0);
    check("arst_elem",    64'(D_ELEM),    64'd0);
    check("arst_running", 64'(RUNNING),   64'd0);
    check("arst_wcyc",    64'(W_CYCLE),   64'd0);
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    p0 = pulses;
    repeat (12) @(negedge CLK);
    check("arst_nopulse", 64'(pulses - p0), 64'd0);
    check("arst_idle",    64'(RUNNING),     64'd0);
    busy_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
